// File: rtl/video_capture.sv
// Frame grabber: converts RGB888 pixels to RGB332, packs eight per 64-bit word and
// writes each line into a framebuffer at a programmable stride, one frame per arm.
module video_capture (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        vsyn,
    input  logic        de,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    input  logic        arm,
    input  logic [7:0]  ghlimit,
    output logic [19:0] fb_addr,
    output logic [63:0] fb_wrdata,
    output logic [7:0]  fb_we,
    output logic        fb_en,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [11:0] lines,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;

    state_t      state, state_next;
    logic        vs_q;
    logic        in_line;
    logic [7:0]  glim;
    logic [16:0] line_base;
    logic [7:0]  wcount;
    logic [2:0]  pcount;
    logic [63:0] word_buf;

    logic        vs_rise, arm_go, capturing, sample, line_end;
    logic [7:0]  pix;
    logic [63:0] buf_next;
    logic [17:0] word_sum;
    logic        sum_ovf;
    logic [7:0]  part_mask;
    logic [16:0] base_next;
    logic [11:0] lines_next;
    logic        busy_nxt, done_nxt;
    logic        wr_req;
    logic [63:0] wr_data;
    logic [7:0]  wr_mask;

    assign fsm_state  = state;
    assign vs_rise    = vsyn & ~vs_q;
    assign arm_go     = arm & ((state == IDLE) | (state == DONE));
    assign capturing  = (state == CAPTURE);
    // The pixel presented on the closing vsyn edge belongs to no frame and is not sampled.
    assign sample     = capturing & de & ~vs_rise;
    assign line_end   = capturing & in_line & (~de | vs_rise);
    assign pix        = {red[7:5], green[7:5], blue[7:6]};
    assign buf_next   = word_buf | ({56'd0, pix} << {pcount, 3'b000});
    assign word_sum   = {1'b0, line_base} + {10'd0, wcount};
    assign sum_ovf    = overflow | (word_sum[17:16] != 2'b00);
    assign part_mask  = (8'd1 << pcount) - 8'd1;
    // Once past 16 bits every address overflows, so the base just parks there.
    assign base_next  = line_base[16] ? line_base : line_base + {9'd0, glim};
    assign lines_next = (lines == 12'hFFF) ? lines : lines + 12'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (arm)     state_next = ARMED;
            ARMED:   if (vs_rise) state_next = CAPTURE;
            CAPTURE: if (vs_rise) state_next = DONE;
            DONE:    if (arm)     state_next = ARMED;
            default:              state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_nxt = (state == ARMED) | (state == CAPTURE);
        done_nxt = (state == DONE);
    end

    always_comb begin
        wr_req  = 1'b0;
        wr_data = buf_next;
        wr_mask = 8'hFF;
        if (sample && (wcount < glim) && (pcount == 3'd7)) begin
            wr_req = 1'b1;
        end else if (line_end && (pcount != 3'd0)) begin
            wr_req  = 1'b1;
            wr_data = word_buf;
            wr_mask = part_mask;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vs_q      <= 1'b0;
            in_line   <= 1'b0;
            glim      <= 8'd0;
            line_base <= 17'd0;
            wcount    <= 8'd0;
            pcount    <= 3'd0;
            word_buf  <= 64'd0;
            fb_addr   <= 20'h80000;
            fb_wrdata <= 64'd0;
            fb_we     <= 8'd0;
            fb_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            lines     <= 12'd0;
        end else begin
            vs_q  <= vsyn;
            busy  <= busy_nxt;
            done  <= done_nxt;
            fb_en <= 1'b0;
            fb_we <= 8'd0;
            if (arm_go) begin
                glim      <= ghlimit;
                in_line   <= 1'b0;
                line_base <= 17'd0;
                wcount    <= 8'd0;
                pcount    <= 3'd0;
                word_buf  <= 64'd0;
                overflow  <= 1'b0;
                lines     <= 12'd0;
            end else begin
                if (wr_req) begin
                    if (sum_ovf) begin
                        overflow <= 1'b1;
                    end else begin
                        fb_en     <= 1'b1;
                        fb_we     <= wr_mask;
                        fb_wrdata <= wr_data;
                        fb_addr   <= {1'b1, word_sum[15:0], 3'b000};
                    end
                end
                if (sample) begin
                    in_line <= 1'b1;
                    if (wcount < glim) begin
                        if (pcount == 3'd7) begin
                            word_buf <= 64'd0;
                            pcount   <= 3'd0;
                            wcount   <= wcount + 8'd1;
                        end else begin
                            word_buf <= buf_next;
                            pcount   <= pcount + 3'd1;
                        end
                    end
                end else if (line_end) begin
                    in_line   <= 1'b0;
                    word_buf  <= 64'd0;
                    pcount    <= 3'd0;
                    wcount    <= 8'd0;
                    line_base <= base_next;
                    lines     <= lines_next;
                end
            end
        end
    end

endmodule

// File: doc/video_capture.md
VIDEO_CAPTURE -- requirements
Module: video_capture

Interface
REQ-001 SHALL have port clk_i, input, 1, the single clock for all logic.
REQ-002 SHALL have port rst_i, input, 1, the reset; synchronous and active-high.
REQ-003 SHALL have port vsyn, input, 1, the frame sync, active-high.
REQ-004 SHALL have port de, input, 1, the data enable, high during active pixels of a line.
REQ-005 SHALL have ports red, green and blue, input, 8 each, the pixel colour, sampled when de=1.
REQ-006 SHALL have port arm, input, 1, a one-cycle request to capture the next frame.
REQ-007 SHALL have port ghlimit, input, 8, the line stride and maximum words per line, in 64-bit words; sampled on the arming cycle.
REQ-008 SHALL have port fb_addr, output, 20, the byte address: bit19=1, bits[18:3] the word address, bits[2:0]=0.
REQ-009 SHALL have port fb_wrdata, output, 64, the packed pixel word.
REQ-010 SHALL have port fb_we, output, 8, the per-byte write enables.
REQ-011 SHALL have port fb_en, output, 1, the write strobe, asserted for one cycle per word.
REQ-012 SHALL have ports busy, done and overflow, output, 1 each, the status flags.
REQ-013 SHALL have port lines, output, 12, the count of lines captured in the current or last frame.

Function
REQ-014 SHALL implement the states IDLE, ARMED, CAPTURE and DONE.
REQ-015 SHALL transition IDLE->ARMED on arm=1, and DONE->ARMED on arm=1.
REQ-016 SHALL ignore arm while in ARMED or CAPTURE.
REQ-017 SHALL, on entering ARMED, clear lines, overflow, line_base and word index, and latch ghlimit.
REQ-018 SHALL transition ARMED->CAPTURE on a vsyn rising edge, detected as the registered previous vsyn=0 and the current vsyn=1.
REQ-019 SHALL transition CAPTURE->DONE on the next vsyn rising edge.
REQ-020 SHALL drive busy=1 in ARMED and CAPTURE, and done=1 only in DONE.
REQ-021 SHALL, in CAPTURE with de=1, convert each pixel to the 8-bit value {red[7:5],green[7:5],blue[7:6]}.
REQ-022 SHALL pack pixels into a word with pixel k of the word in bits [8k+7:8k], k=0..7, pixel 0 being the first in the line.
REQ-023 SHALL issue a write when the 8th pixel of a word is sampled at cycle N, with fb_en=1 and fb_we=8'hFF at cycle N+1.
REQ-024 SHALL set fb_addr[18:3] = line_base + word index (16-bit sum) for each write.
REQ-025 SHALL keep all outputs registered.
REQ-026 SHALL drop pixels beyond ghlimit*8 in a line without writing them.
REQ-027 SHALL, on a falling edge of de with a partial word (1..7 pixels), flush that word on the following cycle, with fb_we set only for the valid low bytes and the unused bytes zero.
REQ-028 SHALL, on each de falling edge in CAPTURE, add ghlimit to line_base, reset the word index to 0 and increment lines (saturating at 4095).
REQ-029 SHALL treat a vsyn rising edge during de=1 as a line end: flush any partial word, increment lines, then enter DONE.
REQ-030 SHALL, with ghlimit=0, issue no writes while still counting lines.
REQ-031 SHALL, when line_base + word index exceeds 16'hFFFF, set overflow (sticky until the next arming), suppress that write and all further writes, and still count lines.
REQ-032 SHALL hold fb_en=0 and fb_we=0 when no write is issued, with fb_wrdata don't-care.

Reset
REQ-033 SHALL, while rst_i=1 at a clk_i edge, force state IDLE, fb_en=0, fb_we=0, fb_addr=20'h80000, fb_wrdata=0, busy=0, done=0, overflow=0, lines=0 and the packer empty.
REQ-034 SHALL, on reset during CAPTURE, abandon any partial word without writing it, with the next capture requiring a new arm.

Verification
REQ-035 SHALL cover: ghlimit=2, arm, vsyn pulse, one line of 16 pixels red=8'hE0 and others 0, vsyn pulse -> two writes, fb_addr 20'h80000 then 20'h80008, fb_wrdata 64'hE0E0E0E0E0E0E0E0, fb_we 8'hFF, lines=1, done=1.
REQ-036 SHALL cover: ghlimit=4, a line of 11 pixels of value 8'h1C -> writes at word 0 with fb_we 8'hFF, then word 1 with fb_we 8'h07 and fb_wrdata 64'h00000000001C1C1C.
REQ-037 SHALL cover: ghlimit=1, three lines of 24 pixels -> exactly 3 writes at words 0, 1 and 2, lines=3.
REQ-038 SHALL cover: ghlimit=255, 300 lines of 2040 pixels -> overflow=1 from line 258 onward, no fb_en after it, lines=300.
REQ-039 SHALL cover: vsyn rising with de high after 5 pixels -> a flush with fb_we 8'h1F, then done=1 on the following cycle.
REQ-040 SHALL cover: rst_i asserted mid-line after 3 pixels -> no write, state IDLE, and arm followed by a frame captures normally.
